// File: rtl/fpu_lzd_norm_scheduler.sv
// fpu_lzd_norm_scheduler
// Shares one leading-zero-detect/normalize datapath between the add/sub
// result path (requester 0) and the mul result path (requester 1).
// Round-robin arbitration, stage 1 holds the granted operand, stage 2 holds
// the normalized result. Valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_ready per-requester handshake (bit 0 add/sub, bit 1 mul)
//   reqN_man/exp/sign/tag  un-normalized operand from requester N
//   out_valid/out_ready result handshake
//   out_man/exp/sign/tag   normalized result and pass-through fields
//   out_src             requester index that produced the result
//   out_zero/out_uflow  zero-significand and exponent-underflow flags
module fpu_lzd_norm_scheduler #(
  parameter int unsigned MAN_W = 16,
  parameter int unsigned EXP_W = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [MAN_W-1:0] req0_man,
  input  logic [MAN_W-1:0] req1_man,
  input  logic [EXP_W-1:0] req0_exp,
  input  logic [EXP_W-1:0] req1_exp,
  input  logic             req0_sign,
  input  logic             req1_sign,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAN_W-1:0] out_man,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_sign,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_src,
  output logic             out_zero,
  output logic             out_uflow
);

  localparam int unsigned LZ_W = $clog2(MAN_W + 1);

  // Arbiter pointer and stage 1 operand
  logic             ptr_q, ptr_d;
  logic             s1_valid_q, s1_valid_d;
  logic [MAN_W-1:0] s1_man_q, s1_man_d;
  logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
  logic             s1_sign_q, s1_sign_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s1_src_q, s1_src_d;

  // Stage 2 result
  logic             out_valid_q, out_valid_d;
  logic [MAN_W-1:0] out_man_q, out_man_d;
  logic [EXP_W-1:0] out_exp_q, out_exp_d;
  logic             out_sign_q, out_sign_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_src_q, out_src_d;
  logic             out_zero_q, out_zero_d;
  logic             out_uflow_q, out_uflow_d;

  logic             s1_accept, s2_accept, xfer;
  logic [1:0]       grant;
  logic [LZ_W-1:0]  lz;
  logic             n_zero, n_uflow;
  logic [MAN_W-1:0] n_man;
  logic [EXP_W-1:0] n_exp;

  // Stall chain and round-robin grant; independent of operand data
  always_comb begin
    s2_accept = !out_valid_q || out_ready;
    s1_accept = !s1_valid_q || s2_accept;
    grant     = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
    req_ready = rst ? 2'b00 : (grant & {2{s1_accept}});
    xfer      = |(req_valid & req_ready);
  end

  // Stage 1 next state; pointer moves to the requester that lost
  always_comb begin
    ptr_d      = ptr_q;
    s1_valid_d = s1_valid_q;
    s1_man_d   = s1_man_q;
    s1_exp_d   = s1_exp_q;
    s1_sign_d  = s1_sign_q;
    s1_tag_d   = s1_tag_q;
    s1_src_d   = s1_src_q;
    if (xfer) begin
      ptr_d = req_ready[0];
    end
    if (s1_accept) begin
      s1_valid_d = xfer;
      if (xfer) begin
        s1_src_d  = req_ready[1];
        s1_man_d  = req_ready[1] ? req1_man  : req0_man;
        s1_exp_d  = req_ready[1] ? req1_exp  : req0_exp;
        s1_sign_d = req_ready[1] ? req1_sign : req0_sign;
        s1_tag_d  = req_ready[1] ? req1_tag  : req0_tag;
      end
    end
  end

  // Leading-zero count: the highest set bit wins since later iterations overwrite
  always_comb begin
    lz = LZ_W'(MAN_W);
    for (int i = 0; i < int'(MAN_W); i++) begin
      if (s1_man_q[i]) lz = LZ_W'(int'(MAN_W) - 1 - i);
    end
  end

  // Normalize; exp <= lz flushes, so the subtract below never wraps
  always_comb begin
    n_zero  = (s1_man_q == '0);
    n_uflow = !n_zero && (s1_exp_q <= EXP_W'(lz));
    n_man   = '0;
    n_exp   = '0;
    if (!n_zero && !n_uflow) begin
      n_man = s1_man_q << lz;
      n_exp = s1_exp_q - EXP_W'(lz);
    end
  end

  // Stage 2 next state
  always_comb begin
    out_valid_d = out_valid_q;
    out_man_d   = out_man_q;
    out_exp_d   = out_exp_q;
    out_sign_d  = out_sign_q;
    out_tag_d   = out_tag_q;
    out_src_d   = out_src_q;
    out_zero_d  = out_zero_q;
    out_uflow_d = out_uflow_q;
    if (s2_accept) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_man_d   = n_man;
        out_exp_d   = n_exp;
        out_sign_d  = s1_sign_q;
        out_tag_d   = s1_tag_q;
        out_src_d   = s1_src_q;
        out_zero_d  = n_zero;
        out_uflow_d = n_uflow;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_man_q    <= '0;
      s1_exp_q    <= '0;
      s1_sign_q   <= 1'b0;
      s1_tag_q    <= '0;
      s1_src_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_man_q   <= '0;
      out_exp_q   <= '0;
      out_sign_q  <= 1'b0;
      out_tag_q   <= '0;
      out_src_q   <= 1'b0;
      out_zero_q  <= 1'b0;
      out_uflow_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_man_q    <= s1_man_d;
      s1_exp_q    <= s1_exp_d;
      s1_sign_q   <= s1_sign_d;
      s1_tag_q    <= s1_tag_d;
      s1_src_q    <= s1_src_d;
      out_valid_q <= out_valid_d;
      out_man_q   <= out_man_d;
      out_exp_q   <= out_exp_d;
      out_sign_q  <= out_sign_d;
      out_tag_q   <= out_tag_d;
      out_src_q   <= out_src_d;
      out_zero_q  <= out_zero_d;
      out_uflow_q <= out_uflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_man   = out_man_q;
  assign out_exp   = out_exp_q;
  assign out_sign  = out_sign_q;
  assign out_tag   = out_tag_q;
  assign out_src   = out_src_q;
  assign out_zero  = out_zero_q;
  assign out_uflow = out_uflow_q;

endmodule

// File: tb/tb_fpu_lzd_norm_scheduler.sv
// Bench for fpu_lzd_norm_scheduler: directed cases plus a random stream,
// with a scoreboard of expected results pushed at accept, popped at output.
module tb_fpu_lzd_norm_scheduler;

  localparam int unsigned MAN_W = 16;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [MAN_W-1:0] req_man [2];
  logic [EXP_W-1:0] req_exp [2];
  logic             req_sign [2];
  logic [TAG_W-1:0] req_tag [2];
  logic             out_valid, out_ready;
  logic [MAN_W-1:0] out_man;
  logic [EXP_W-1:0] out_exp;
  logic             out_sign, out_src, out_zero, out_uflow;
  logic [TAG_W-1:0] out_tag;

  fpu_lzd_norm_scheduler #(.MAN_W(MAN_W), .EXP_W(EXP_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_man(req_man[0]), .req1_man(req_man[1]),
    .req0_exp(req_exp[0]), .req1_exp(req_exp[1]),
    .req0_sign(req_sign[0]), .req1_sign(req_sign[1]),
    .req0_tag(req_tag[0]), .req1_tag(req_tag[1]),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_man(out_man), .out_exp(out_exp), .out_sign(out_sign),
    .out_tag(out_tag), .out_src(out_src),
    .out_zero(out_zero), .out_uflow(out_uflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference normalizer; record = {man, exp, sign, tag, src, zero, uflow}
  function automatic logic [31:0] ref_norm(input logic [15:0] man, input logic [7:0] e,
                                           input logic s, input logic [3:0] t, input logic src);
    logic [15:0] m;
    logic [7:0]  oe;
    logic        z, u;
    int          lz;
    m = man; oe = 8'd0; z = 1'b0; u = 1'b0; lz = 0;
    if (man == 16'd0) begin
      z = 1'b1;
    end else begin
      while (!m[15]) begin
        m = m << 1;
        lz++;
      end
      if (int'(e) <= lz) begin
        u = 1'b1;
        m = 16'd0;
      end else begin
        oe = e - 8'(lz);
      end
    end
    return {m, oe, s, t, src, z, u};
  endfunction

  logic [31:0] exp_q[$];
  int          acc_cyc_q[$];
  int          grant_log[$];
  logic [1:0]  acc;
  logic [31:0] last_obs, prev_obs;
  bit          prev_stall;
  bit          chk_lat;
  int          cyc;
  int          n_acc;
  int          waitc [2];

  function automatic logic [31:0] obs_rec();
    return {out_man, out_exp, out_sign, out_tag, out_src, out_zero, out_uflow};
  endfunction

  // Observe at negedge: outputs, stall stability, accepts, fairness
  task automatic monitor();
    logic [31:0] o;
    cyc++;
    o = obs_rec();
    if (prev_stall) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_hold", o, prev_obs);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'd1, 32'd0);
      end else begin
        int c;
        check("out_rec", o, exp_q.pop_front());
        c = acc_cyc_q.pop_front();
        if (chk_lat) check("latency", 32'(cyc - c), 32'd2);
      end
      last_obs = o;
    end
    prev_stall = out_valid && !out_ready;
    prev_obs   = o;
    check("ready_onehot", 32'(req_ready & (req_ready - 2'b01)), 32'd0);
    acc = req_valid & req_ready;
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        exp_q.push_back(ref_norm(req_man[i], req_exp[i], req_sign[i], req_tag[i], 1'(i)));
        acc_cyc_q.push_back(cyc);
        grant_log.push_back(i);
        n_acc++;
      end
    end
    if (req_valid == 2'b11) begin
      for (int i = 0; i < 2; i++) begin
        if (acc[1-i]) begin
          waitc[i]++;
          check("starve", 32'(waitc[i] <= 1), 32'd1);
        end
      end
    end
    for (int i = 0; i < 2; i++) if (acc[i]) waitc[i] = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_q.delete(); acc_cyc_q.delete(); grant_log.delete();
    prev_stall = 0; waitc[0] = 0; waitc[1] = 0; acc = 2'b00;
  endtask

  task automatic set_req(input int i, input logic [15:0] m, input logic [7:0] e,
                         input logic s, input logic [3:0] t);
    req_man[i] = m; req_exp[i] = e; req_sign[i] = s; req_tag[i] = t;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send(input int i, input logic [15:0] m, input logic [7:0] e,
                      input logic s, input logic [3:0] t);
    int n;
    set_req(i, m, e, s, t);
    req_valid = 2'b00;
    req_valid[i] = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc[i] && n < 50);
    check("send_timeout", 32'(acc[i]), 32'd1);
    req_valid = 2'b00;
  endtask

  initial begin
    bit          pend [2];
    int          target, n, cnt;
    rst = 1'b1; req_valid = 2'b00; out_ready = 1'b1; chk_lat = 0;
    cyc = 0; n_acc = 0; last_obs = '0; prev_obs = '0;
    set_req(0, 16'd0, 8'd0, 1'b0, 4'd0);
    set_req(1, 16'd0, 8'd0, 1'b0, 4'd0);
    clear_sb();

    // Reset state
    #2;
    req_valid = 2'b11;
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_fields", obs_rec(), 32'd0);
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single op, latency 2
    chk_lat = 1;
    send(0, 16'h0300, 8'd130, 1'b0, 4'd3);
    drain();
    check("single_op", last_obs, {16'hC000, 8'd124, 1'b0, 4'd3, 1'b0, 2'b00});

    // Zero, underflow and boundary from the mul path
    send(1, 16'h0000, 8'd100, 1'b1, 4'd5);
    drain();
    check("zero_case", last_obs, {16'h0000, 8'd0, 1'b1, 4'd5, 1'b1, 2'b10});
    send(1, 16'h0001, 8'd15, 1'b0, 4'd6);
    drain();
    check("uflow_case", last_obs, {16'h0000, 8'd0, 1'b0, 4'd6, 1'b1, 2'b01});
    send(1, 16'h0001, 8'd16, 1'b1, 4'd7);
    drain();
    check("exp_boundary", last_obs, {16'h8000, 8'd1, 1'b1, 4'd7, 1'b1, 2'b00});

    // Backpressure: two operands fill the pipe, then ready drops
    chk_lat = 0;
    out_ready = 1'b0;
    set_req(0, 16'h1234, 8'd90, 1'b0, 4'd1);
    set_req(1, 16'h00F0, 8'd40, 1'b1, 4'd2);
    req_valid = 2'b11;
    cnt = n_acc;
    repeat (5) begin
      tick();
      for (int i = 0; i < 2; i++) if (acc[i]) req_tag[i] = req_tag[i] + 4'd4;
    end
    check("bp_accepts", 32'(n_acc - cnt), 32'd2);
    check("bp_ready", 32'(req_ready), 32'd0);
    req_valid = 2'b00;
    out_ready = 1'b1;
    drain();

    // Async reset with both stages full
    out_ready = 1'b0;
    req_valid = 2'b11;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_ready", 32'(req_ready), 32'd0);
    clear_sb();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Both continuously valid: strict alternation starting at requester 0
    out_ready = 1'b1;
    chk_lat = 1;
    req_valid = 2'b11;
    repeat (6) begin
      tick();
      for (int i = 0; i < 2; i++) if (acc[i]) req_man[i] = req_man[i] + 16'h0111;
    end
    req_valid = 2'b00;
    for (int k = 0; k < 6; k++) begin
      if (k < grant_log.size()) check("alt_grant", 32'(grant_log[k]), 32'(k % 2));
      else check("alt_missing", 32'(grant_log.size()), 32'd6);
    end
    drain();

    // Random stream with random backpressure
    chk_lat = 0;
    pend[0] = 0; pend[1] = 0;
    target = n_acc + 10000;
    n = 0;
    while (n_acc < target && n < 60000) begin
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) pend[i] = 0;
        if (!pend[i] && $urandom_range(0, 99) < 70) begin
          logic [15:0] m;
          m = 16'($urandom) >> $urandom_range(0, 16);
          if ($urandom_range(0, 15) == 0) m = 16'd0;
          set_req(i, m, 8'($urandom_range(0, 3) == 0 ? $urandom_range(0, 20) : $urandom_range(0, 255)),
                  1'($urandom), 4'($urandom));
          pend[i] = 1;
        end
        req_valid[i] = pend[i];
      end
      out_ready = ($urandom_range(0, 3) != 0);
      acc = 2'b00;
      tick();
      n++;
    end
    check("rand_timeout", 32'(n_acc >= target), 32'd1);
    req_valid = 2'b00;
    out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
